aes_128_key_switch_ctrl: RTL and testbench
==========================================

# aes_128_key_switch_ctrl

Controller between a host key/data source and `aes_128_top` built in TWO_KEY mode. It streams a 22-word round-key set into the core's inactive key buffer via `en_wr`/`key_round_wr` while traffic continues on the active buffer. It then drains in-flight blocks, pulses `switch_key`, and confirms the buffer swap through `key_idx`. Host data blocks pass through a valid/ready front end that is stalled only during the drain/switch window.

## Interface
Parameters:
- `KEY_WORDS`, 22, number of 64-bit round-key words per set (11 rounds × 2).
- `DRAIN_GUARD`, 2, minimum DRAIN cycles before `idle` is trusted.
- `SWITCH_TO`, 16, cycles allowed for `key_idx` to flip after `switch_key`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `kill`  in  1  reset, asynchronous, active-high.
- `cfg_start`  in  1  one-cycle pulse; begin loading a new key set.
- `key_valid`  in  1  host key word valid.
- `key_ready`  out  1  controller accepts key word.
- `key_data`  in  64  round-key word; word 0 = low half of round 0, word 1 = high half of round 0, and so on.
- `s_valid`  in  1  host data block valid.
- `s_ready`  out  1  controller accepts data block.
- `s_data`  in  128  plaintext block.
- `in_en`  out  1  to core; registered `s_valid & s_ready`.
- `in_data`  out  128  to core; registered `s_data`.
- `en_wr`  out  1  to core key-write strobe.
- `key_round_wr`  out  64  to core key word.
- `switch_key`  out  1  to core; one-cycle buffer swap pulse.
- `key_idx`  in  1  from core; currently active key buffer.
- `idle`  in  1  from core; pipeline empty.
- `busy`  out  1  state ≠ IDLE.
- `load_done`  out  1  one-cycle pulse; swap confirmed.
- `err_pulse`  out  1  one-cycle pulse; start-while-busy or swap timeout.

## Operation
- States:
  - IDLE: `key_ready=0`. `cfg_start` → LOAD, clears `wcnt`.
  - LOAD: `key_ready=1`. Each `key_valid&key_ready` beat increments `wcnt` (5 bits). The beat with `wcnt==KEY_WORDS-1` → DRAIN.
  - DRAIN: `s_ready=0`, `gcnt` counts up. Once `gcnt>=DRAIN_GUARD-1` and `idle==1` → SWITCH.
  - SWITCH: one cycle. `switch_key=1`, latch `exp_idx = ~key_idx`, → CONFIRM.
  - CONFIRM: `tcnt` counts up.
    - `key_idx==exp_idx` → IDLE with `load_done`.
    - `tcnt==SWITCH_TO-1` without a match → IDLE with `err_pulse`.
- `s_ready=1` in IDLE and LOAD; `s_ready=0` in DRAIN, SWITCH and CONFIRM. Data and key loading proceed concurrently in LOAD, because writes target the inactive buffer.
- `cfg_start` while `busy`: ignored, `err_pulse` for one cycle, current load continues.
- `cfg_start` in the same cycle as the CONFIRM→IDLE exit: ignored, no error. The start is sampled only in IDLE.
- `key_valid` outside LOAD: not accepted; the host holds it.

## Timing
- Reset values while `kill`=1: state IDLE, all counters 0, and every output 0 (`key_ready`, `s_ready`, `in_en`, `in_data`, `en_wr`, `key_round_wr`, `switch_key`, `busy`, `load_done`, `err_pulse`).
- First cycle after `kill` deasserts: `s_ready=1`.
- Key path latency is 1 cycle: a word accepted at edge N drives `en_wr=1`/`key_round_wr=word` during cycle N+1. `en_wr=0` otherwise, and `key_round_wr` returns to 0.
- Data path latency is 1 cycle: a block accepted at N drives `in_en` during N+1. `in_en` is never high for 2 cycles from a single beat.
- Last key word accepted at N:
  - DRAIN starts at N+1, and `s_ready` is already 0 in N+1.
  - The last `en_wr` occurs at N+1.
  - Earliest `switch_key` is N+1+DRAIN_GUARD.
- `load_done` is high in the first IDLE cycle after the `key_idx` match. Minimum start-to-done time is 1 + KEY_WORDS + DRAIN_GUARD + 2 cycles.
- A `kill` assertion mid-LOAD or mid-DRAIN aborts immediately: `switch_key` is never issued. The partially written inactive buffer is the host's responsibility.

## Test plan
- **Basic load:** after reset, `cfg_start`, then 22 back-to-back words (0x0706050403020100, 0x0f0e0d0c0b0a0908, …, 0xc5302b4d8ba707f3) with `idle=1` and the core model toggling `key_idx` one cycle after `switch_key`.
  - Expect 22 `en_wr` cycles with matching data.
  - Expect `switch_key` 2 cycles after the last `en_wr`.
  - Expect `load_done` once; `busy` low afterwards.
- **Concurrent traffic:** during LOAD, stream `s_data=0xffeeddccbbaa99887766554433221100` every cycle.
  - Expect `in_en` to follow each accepted beat by 1 cycle.
  - Expect `s_ready` to drop in the cycle after the last key word and return only after `load_done`.
- **Drain wait:** hold `idle=0` for 10 cycles in DRAIN.
  - Expect no `switch_key` until 1 cycle after `idle` rises.
  - Expect no `in_en` during the wait.
- **Swap timeout:** the core model never flips `key_idx`.
  - Expect `err_pulse` exactly 16 cycles after `switch_key`, then IDLE with no `load_done`.
- **Protocol error:** `cfg_start` pulsed during LOAD at word 5.
  - Expect one `err_pulse`; the load completes with exactly 22 writes.
- **Reset mid-op:** assert `kill` at word 10.
  - Expect all outputs 0 while `kill` is high and no `switch_key`.
  - A new load after release completes normally with `wcnt` starting at 0.

Source files
------------

// File: rtl/aes_128_key_switch_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_128_key_switch_ctrl_if
// Groups every non-clock signal of the key-switch controller.
//   Host side : cfg_start, key_valid/key_ready/key_data, s_valid/s_ready/s_data
//   Core side : in_en/in_data, en_wr/key_round_wr, switch_key, key_idx, idle
//   Status    : busy, load_done, err_pulse
// Modports:
//   slave  - the controller (consumes host and core inputs, drives the rest)
//   master - the environment (host, core model or testbench)
// ---------------------------------------------------------------------------
interface aes_128_key_switch_ctrl_if;
    logic         cfg_start;
    logic         key_valid;
    logic         key_ready;
    logic [63:0]  key_data;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         in_en;
    logic [127:0] in_data;
    logic         en_wr;
    logic [63:0]  key_round_wr;
    logic         switch_key;
    logic         key_idx;
    logic         idle;
    logic         busy;
    logic         load_done;
    logic         err_pulse;

    modport slave (
        input  cfg_start, key_valid, key_data, s_valid, s_data, key_idx, idle,
        output key_ready, s_ready, in_en, in_data, en_wr, key_round_wr,
               switch_key, busy, load_done, err_pulse
    );

    modport master (
        output cfg_start, key_valid, key_data, s_valid, s_data, key_idx, idle,
        input  key_ready, s_ready, in_en, in_data, en_wr, key_round_wr,
               switch_key, busy, load_done, err_pulse
    );
endinterface

// File: rtl/aes_128_key_switch_ctrl.sv
// ---------------------------------------------------------------------------
// aes_128_key_switch_ctrl
// Loads a fresh round-key set into the inactive key buffer of a two-key AES
// core while data keeps flowing on the active buffer, then drains the core,
// pulses switch_key and confirms the swap through key_idx.
//
// Ports:
//   clk  - single rising-edge clock
//   kill - asynchronous active-high reset
//   bus  - aes_128_key_switch_ctrl_if.slave:
//          host key stream (key_valid/key_ready/key_data), host data stream
//          (s_valid/s_ready/s_data), core write strobes (in_en/in_data,
//          en_wr/key_round_wr), swap handshake (switch_key/key_idx/idle),
//          status (busy, load_done, err_pulse)
// ---------------------------------------------------------------------------
module aes_128_key_switch_ctrl #(
    parameter int KEY_WORDS   = 22,
    parameter int DRAIN_GUARD = 2,
    parameter int SWITCH_TO   = 16
) (
    input  logic                        clk,
    input  logic                        kill,
    aes_128_key_switch_ctrl_if.slave    bus
);

    localparam int GW = (DRAIN_GUARD < 2) ? 1 : $clog2(DRAIN_GUARD + 1);
    localparam int TW = $clog2(SWITCH_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_SWITCH,
        S_CONFIRM
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      wcnt_q, wcnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            exp_idx_q, exp_idx_d;

    logic            s_ready_q, s_ready_d;
    logic            in_en_q, in_en_d;
    logic [127:0]    in_data_q, in_data_d;
    logic            en_wr_q, en_wr_d;
    logic [63:0]     key_round_wr_q, key_round_wr_d;
    logic            load_done_q, load_done_d;
    logic            err_pulse_q, err_pulse_d;

    logic            key_ready;
    logic            switch_key;
    logic            busy;

    logic            key_acc;
    logic            data_acc;
    logic            last_word;
    logic            guard_met;
    logic            idx_match;
    logic            swap_timeout;
    logic            confirm_exit;

    assign key_acc      = bus.key_valid & (state_q == S_LOAD);
    assign data_acc     = bus.s_valid & s_ready_q;
    assign last_word    = key_acc && (wcnt_q == 5'(KEY_WORDS - 1));
    assign guard_met    = (gcnt_q >= GW'(DRAIN_GUARD - 1));
    assign idx_match    = (bus.key_idx == exp_idx_q);
    // tcnt starts at 0 in SWITCH, so the timeout is measured from switch_key.
    assign swap_timeout = (tcnt_q == TW'(SWITCH_TO - 1));
    assign confirm_exit = (state_q == S_CONFIRM) && (idx_match || swap_timeout);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.cfg_start)           state_d = S_LOAD;
            S_LOAD:    if (last_word)               state_d = S_DRAIN;
            S_DRAIN:   if (guard_met && bus.idle)   state_d = S_SWITCH;
            S_SWITCH:                               state_d = S_CONFIRM;
            S_CONFIRM: if (idx_match || swap_timeout) state_d = S_IDLE;
            default:                                state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        key_ready  = (state_q == S_LOAD);
        switch_key = (state_q == S_SWITCH);
        busy       = (state_q != S_IDLE);

        // s_ready is registered from the next state so it is already low in
        // the first DRAIN cycle and stays low while kill is asserted.
        s_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);

        load_done_d = (state_q == S_CONFIRM) && idx_match;
        // A start that coincides with the CONFIRM exit is silently dropped.
        err_pulse_d = ((state_q == S_CONFIRM) && swap_timeout && !idx_match) ||
                      (bus.cfg_start && (state_q != S_IDLE) && !confirm_exit);
    end

    // ---------------- counters and datapath next state ----------------
    always_comb begin
        wcnt_d = wcnt_q;
        if ((state_q == S_IDLE) && bus.cfg_start) begin
            wcnt_d = '0;
        end else if (key_acc) begin
            wcnt_d = wcnt_q + 5'd1;
        end

        gcnt_d = '0;
        if (state_q == S_DRAIN) begin
            gcnt_d = guard_met ? gcnt_q : gcnt_q + GW'(1);
        end

        tcnt_d = '0;
        if ((state_q == S_SWITCH) || (state_q == S_CONFIRM)) begin
            tcnt_d = tcnt_q + TW'(1);
        end

        exp_idx_d = (state_q == S_SWITCH) ? ~bus.key_idx : exp_idx_q;

        in_en_d        = data_acc;
        in_data_d      = data_acc ? bus.s_data : in_data_q;
        en_wr_d        = key_acc;
        key_round_wr_d = key_acc ? bus.key_data : 64'd0;
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            wcnt_q         <= '0;
            gcnt_q         <= '0;
            tcnt_q         <= '0;
            exp_idx_q      <= 1'b0;
            s_ready_q      <= 1'b0;
            in_en_q        <= 1'b0;
            in_data_q      <= '0;
            en_wr_q        <= 1'b0;
            key_round_wr_q <= '0;
            load_done_q    <= 1'b0;
            err_pulse_q    <= 1'b0;
        end else begin
            wcnt_q         <= wcnt_d;
            gcnt_q         <= gcnt_d;
            tcnt_q         <= tcnt_d;
            exp_idx_q      <= exp_idx_d;
            s_ready_q      <= s_ready_d;
            in_en_q        <= in_en_d;
            in_data_q      <= in_data_d;
            en_wr_q        <= en_wr_d;
            key_round_wr_q <= key_round_wr_d;
            load_done_q    <= load_done_d;
            err_pulse_q    <= err_pulse_d;
        end
    end

    assign bus.key_ready    = key_ready;
    assign bus.s_ready      = s_ready_q;
    assign bus.in_en        = in_en_q;
    assign bus.in_data      = in_data_q;
    assign bus.en_wr        = en_wr_q;
    assign bus.key_round_wr = key_round_wr_q;
    assign bus.switch_key   = switch_key;
    assign bus.busy         = busy;
    assign bus.load_done    = load_done_q;
    assign bus.err_pulse    = err_pulse_q;

endmodule

// File: tb/tb_aes_128_key_switch_ctrl.sv
module tb_aes_128_key_switch_ctrl;

    localparam logic [127:0] D = 128'hffeeddccbbaa99887766554433221100;

    logic clk = 1'b0;
    logic kill;
    logic flip_en;

    aes_128_key_switch_ctrl_if bus();

    aes_128_key_switch_ctrl #(
        .KEY_WORDS  (22),
        .DRAIN_GUARD(2),
        .SWITCH_TO  (16)
    ) dut (
        .clk (clk),
        .kill(kill),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Core model: flips the active buffer one cycle after switch_key.
    always @(posedge clk or posedge kill) begin
        if (kill) bus.key_idx <= 1'b0;
        else if (flip_en && bus.switch_key) bus.key_idx <= ~bus.key_idx;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle.
    logic [63:0] log_wr [256];
    int n_wr = 0, n_sw = 0, n_done = 0, n_err = 0, in_bad = 0;
    int last_wr_cyc = 0, sw_cyc = 0;
    logic prev_acc = 1'b0;

    always @(negedge clk) begin
        if (kill) begin
            prev_acc <= 1'b0;
        end else begin
            if (bus.in_en !== prev_acc) in_bad <= in_bad + 1;
            if (bus.in_en === 1'b1 && bus.in_data !== D) in_bad <= in_bad + 1;
            prev_acc <= bus.s_valid & bus.s_ready;
            if (bus.en_wr === 1'b1) begin
                log_wr[n_wr] <= bus.key_round_wr;
                n_wr         <= n_wr + 1;
                last_wr_cyc  <= cyc;
            end
            if (bus.switch_key === 1'b1) begin
                n_sw   <= n_sw + 1;
                sw_cyc <= cyc;
            end
            if (bus.load_done === 1'b1) n_done <= n_done + 1;
            if (bus.err_pulse === 1'b1) n_err <= n_err + 1;
        end
    end

    int checks = 0;
    int failures = 0;
    logic [63:0]  W  [22];
    logic [127:0] rk [11];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_words(input int base);
        for (int i = 0; i < 22; i++)
            chk($sformatf("key_word_%0d", i), {64'd0, log_wr[base + i]}, {64'd0, W[i]});
    endtask

    task automatic chk_all_zero(input string ctx);
        chk({ctx, "_key_ready"},    {127'd0, bus.key_ready},  128'd0);
        chk({ctx, "_s_ready"},      {127'd0, bus.s_ready},    128'd0);
        chk({ctx, "_in_en"},        {127'd0, bus.in_en},      128'd0);
        chk({ctx, "_in_data"},      bus.in_data,              128'd0);
        chk({ctx, "_en_wr"},        {127'd0, bus.en_wr},      128'd0);
        chk({ctx, "_key_round_wr"}, {64'd0, bus.key_round_wr}, 128'd0);
        chk({ctx, "_switch_key"},   {127'd0, bus.switch_key}, 128'd0);
        chk({ctx, "_busy"},         {127'd0, bus.busy},       128'd0);
        chk({ctx, "_load_done"},    {127'd0, bus.load_done},  128'd0);
        chk({ctx, "_err_pulse"},    {127'd0, bus.err_pulse},  128'd0);
    endtask

    task automatic send_words(input int count);
        for (int i = 0; i < count; i++) begin
            bus.key_valid = 1'b1;
            bus.key_data  = W[i];
            tick();
        end
        bus.key_valid = 1'b0;
        bus.key_data  = 64'd0;
    endtask

    task automatic wait_switch(input string tag);
        int t = 0;
        while (bus.switch_key !== 1'b1 && t < 40) begin tick(); t++; end
        chk({tag, "_switch_seen"}, {127'd0, bus.switch_key}, 128'd1);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (bus.load_done !== 1'b1 && t < 60) begin tick(); t++; end
        chk({tag, "_load_done_seen"}, {127'd0, bus.load_done}, 128'd1);
    endtask

    int c0, wr0, sw0, done0, err0, s_at;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        kill          = 1'b1;
        flip_en       = 1'b1;
        bus.cfg_start = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_data  = 64'd0;
        bus.s_valid   = 1'b0;
        bus.s_data    = D;
        bus.idle      = 1'b1;

        rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        // Byte 0 of each round key sits in the least significant byte.
        for (int r = 0; r < 11; r++) begin
            for (int b = 0; b < 8; b++) begin
                W[2*r][8*b +: 8]   = rk[r][127 - 8*b -: 8];
                W[2*r+1][8*b +: 8] = rk[r][63 - 8*b -: 8];
            end
        end

        // ---------------- reset ----------------
        repeat (3) tick();
        chk_all_zero("reset");
        kill = 1'b0;
        tick();
        chk("post_reset_s_ready", {127'd0, bus.s_ready}, 128'd1);
        chk("post_reset_busy",    {127'd0, bus.busy},    128'd0);
        $display("step reset: outputs cleared, s_ready restored");

        // ---------------- basic load with concurrent traffic ----------------
        bus.s_valid = 1'b1;
        wr0 = n_wr; done0 = n_done; c0 = cyc;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        chk("basic_busy",      {127'd0, bus.busy},      128'd1);
        chk("basic_key_ready", {127'd0, bus.key_ready}, 128'd1);
        chk("basic_s_ready",   {127'd0, bus.s_ready},   128'd1);
        chk("basic_in_en",     {127'd0, bus.in_en},     128'd1);
        send_words(22);
        chk("drain_s_ready_low", {127'd0, bus.s_ready},    128'd0);
        chk("last_en_wr",        {127'd0, bus.en_wr},      128'd1);
        chk("last_key_word",     {64'd0, bus.key_round_wr}, {64'd0, W[21]});
        tick();
        chk("en_wr_cleared",   {127'd0, bus.en_wr},       128'd0);
        chk("key_wr_zeroed",   {64'd0, bus.key_round_wr},  128'd0);
        chk("no_early_switch", {127'd0, bus.switch_key},  128'd0);
        tick();
        chk("switch_at_guard", {127'd0, bus.switch_key},  128'd1);
        wait_done("basic");
        chk("start_to_done", 128'(cyc - c0), 128'd27);
        chk("done_s_ready",  {127'd0, bus.s_ready}, 128'd1);
        chk("done_busy",     {127'd0, bus.busy},    128'd0);
        bus.s_valid = 1'b0;
        tick();
        chk("done_one_cycle", {127'd0, bus.load_done}, 128'd0);
        chk("basic_done_count", 128'(n_done - done0), 128'd1);
        chk("basic_write_count", 128'(n_wr - wr0), 128'd22);
        chk("switch_after_last_wr", 128'(sw_cyc - last_wr_cyc), 128'd2);
        chk_words(wr0);
        $display("step basic_load: 22 words, switch and load_done observed");

        // ---------------- drain wait ----------------
        tick();
        bus.idle = 1'b0;
        bus.s_valid = 1'b1;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        send_words(22);
        chk("drain_last_in_en", {127'd0, bus.in_en}, 128'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("drain_no_switch", {127'd0, bus.switch_key}, 128'd0);
            chk("drain_no_in_en",  {127'd0, bus.in_en},      128'd0);
        end
        bus.idle = 1'b1;
        tick();
        chk("switch_after_idle", {127'd0, bus.switch_key}, 128'd1);
        wait_done("drain");
        bus.s_valid = 1'b0;
        tick();
        $display("step drain_wait: switch held until idle");

        // ---------------- swap timeout ----------------
        flip_en = 1'b0;
        done0 = n_done; sw0 = n_sw;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        send_words(22);
        wait_switch("timeout");
        s_at = cyc;
        begin
            int t = 0;
            while (bus.err_pulse !== 1'b1 && t < 40) begin tick(); t++; end
        end
        chk("timeout_err",       {127'd0, bus.err_pulse}, 128'd1);
        chk("timeout_delay",     128'(cyc - s_at),        128'd16);
        chk("timeout_no_done",   {127'd0, bus.load_done}, 128'd0);
        chk("timeout_idle",      {127'd0, bus.busy},      128'd0);
        tick();
        chk("timeout_err_pulse", {127'd0, bus.err_pulse}, 128'd0);
        chk("timeout_done_count", 128'(n_done - done0),   128'd0);
        chk("timeout_switch_count", 128'(n_sw - sw0),     128'd1);
        flip_en = 1'b1;
        $display("step swap_timeout: err_pulse after 16 cycles");

        // ---------------- protocol error ----------------
        err0 = n_err; wr0 = n_wr; done0 = n_done;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        for (int i = 0; i < 22; i++) begin
            bus.key_valid = 1'b1;
            bus.key_data  = W[i];
            bus.cfg_start = (i == 5);
            tick();
            if (i == 5) chk("start_while_busy_err", {127'd0, bus.err_pulse}, 128'd1);
        end
        bus.cfg_start = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_data  = 64'd0;
        wait_switch("proto");
        tick();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        chk("exit_start_done",   {127'd0, bus.load_done}, 128'd1);
        chk("exit_start_no_err", {127'd0, bus.err_pulse}, 128'd0);
        tick();
        chk("exit_start_ignored", {127'd0, bus.busy},     128'd0);
        chk("proto_err_count",   128'(n_err - err0),      128'd1);
        chk("proto_write_count", 128'(n_wr - wr0),        128'd22);
        chk("proto_done_count",  128'(n_done - done0),    128'd1);
        chk_words(wr0);
        $display("step protocol_error: one err_pulse, load completed");

        // ---------------- reset mid-op ----------------
        sw0 = n_sw;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        send_words(10);
        bus.key_valid = 1'b1;
        bus.key_data  = W[10];
        kill = 1'b1;
        #1;
        chk_all_zero("kill");
        repeat (3) tick();
        chk("kill_held_busy", {127'd0, bus.busy}, 128'd0);
        bus.key_valid = 1'b0;
        bus.key_data  = 64'd0;
        kill = 1'b0;
        tick();
        chk("kill_release_s_ready", {127'd0, bus.s_ready}, 128'd1);
        chk("kill_no_switch", 128'(n_sw - sw0), 128'd0);
        wr0 = n_wr; done0 = n_done;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        send_words(22);
        chk("reload_drain_s_ready", {127'd0, bus.s_ready}, 128'd0);
        wait_done("reload");
        tick();
        chk("reload_write_count", 128'(n_wr - wr0),     128'd22);
        chk("reload_done_count",  128'(n_done - done0), 128'd1);
        chk_words(wr0);
        chk("in_en_follow", 128'(in_bad), 128'd0);
        $display("step reset_mid_op: abort clean, reload completed");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
